// File: rtl/etapa_id_vec_param.sv
`default_nettype none
// ============================================================================
//  Module      : etapa_id_vec_param
//  Description : Vector processor decode stage. Holds the vector and scalar
//                register files, decodes 14-bit instructions, tracks pending
//                vector writes in a scoreboard and hands decoded operands to
//                EX through a valid/ready ID/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
module etapa_id_vec_param #(
    parameter int LANES    = 4,
    parameter int ELEM_W   = 8,
    parameter int NUM_VREG = 8,
    parameter int NUM_SREG = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [13:0]               instruccion,
    input  logic                      sel_dest,
    input  logic                      reg_rdv,
    input  logic                      reg_rds,
    input  logic                      dest_vec,
    input  logic                      wb_wrv,
    input  logic                      wb_wrs,
    input  logic [3:0]                i_dir_wr,
    input  logic [LANES*ELEM_W-1:0]   data_wrv,
    input  logic [ELEM_W-1:0]         data_wrs,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [3:0]                opcode_out,
    output logic [2:0]                dir_dest_out,
    output logic [LANES*ELEM_W-1:0]   data_vec1,
    output logic [LANES*ELEM_W-1:0]   data_vec2,
    output logic [ELEM_W-1:0]         data_sca1,
    output logic [ELEM_W-1:0]         inmediato,
    output logic [ELEM_W-1:0]         shift,
    output logic [LANES*ELEM_W-1:0]   VFS,
    output logic [NUM_VREG-1:0]       busy_mask
);

    localparam int C_VW = LANES * ELEM_W;

    logic [C_VW-1:0]     r_vreg [NUM_VREG];
    logic [ELEM_W-1:0]   r_sreg [NUM_SREG];
    logic [NUM_VREG-1:0] r_busy;

    logic [3:0]          w_opcode;
    logic [2:0]          w_src1;
    logic [2:0]          w_src2;
    logic [2:0]          w_dest;
    logic [2:0]          w_wr_addr;
    logic [NUM_VREG-1:0] w_wbmask;
    logic [7:0]          w_busyp;
    logic [NUM_VREG-1:0] w_busy_nxt;
    logic [C_VW-1:0]     w_vec1;
    logic [C_VW-1:0]     w_vec2;
    logic [ELEM_W-1:0]   w_sca;
    logic                w_hz;
    logic                w_advance;
    logic                w_issue;
    logic                w_unused;

    // Only the low three address bits select a register.
    assign w_unused  = i_dir_wr[3];
    assign w_wr_addr = i_dir_wr[2:0];

    assign w_opcode  = instruccion[13:10];
    assign w_src1    = instruccion[5:3];
    assign w_src2    = instruccion[2:0];
    assign w_dest    = sel_dest ? {1'b0, instruccion[9:8]} : instruccion[8:6];

    // Scoreboard view with this cycle's write-back already retired; padded to
    // eight entries so any 3-bit field can index it (missing regs never busy).
    always_comb begin
        w_wbmask = '0;
        w_busyp  = '0;
        for (int i = 0; i < NUM_VREG; i++) begin
            w_wbmask[i] = wb_wrv && (int'(w_wr_addr) == i);
            w_busyp[i]  = r_busy[i] & ~w_wbmask[i];
        end
    end

    assign w_hz      = (reg_rdv & (w_busyp[w_src1] | w_busyp[w_src2])) |
                       (dest_vec & w_busyp[w_dest]);
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance & ~w_hz;
    assign w_issue   = in_valid & in_ready;

    // Operand reads with write-through from the write-back port; disabled
    // reads and out-of-range addresses yield zero.
    always_comb begin
        w_vec1 = '0;
        w_vec2 = '0;
        w_sca  = '0;
        for (int i = 0; i < NUM_VREG; i++) begin
            if (reg_rdv && (int'(w_src1) == i))
                w_vec1 = w_wbmask[i] ? data_wrv : r_vreg[i];
            if (reg_rdv && (int'(w_src2) == i))
                w_vec2 = w_wbmask[i] ? data_wrv : r_vreg[i];
        end
        for (int i = 0; i < NUM_SREG; i++) begin
            if (reg_rds && (int'(w_src2) == i))
                w_sca = (wb_wrs && (int'(w_wr_addr) == i)) ? data_wrs : r_sreg[i];
        end
    end

    // Next scoreboard: retire the write-back target, then mark a new issue
    // (set after clear so a same-register set wins).
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < NUM_VREG; i++) begin
            w_busy_nxt[i] = (r_busy[i] & ~w_wbmask[i]) |
                            (w_issue & dest_vec & (int'(w_dest) == i));
        end
    end

    // Register files and scoreboard update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VREG; i++) r_vreg[i] <= '0;
            for (int i = 0; i < NUM_SREG; i++) r_sreg[i] <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_VREG; i++)
                if (w_wbmask[i]) r_vreg[i] <= data_wrv;
            for (int i = 0; i < NUM_SREG; i++)
                if (wb_wrs && (int'(w_wr_addr) == i)) r_sreg[i] <= data_wrs;
            r_busy <= w_busy_nxt;
        end
    end

    // ID/EX register: load on issue, drain when EX takes it, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            opcode_out   <= '0;
            dir_dest_out <= '0;
            data_vec1    <= '0;
            data_vec2    <= '0;
            data_sca1    <= '0;
            inmediato    <= '0;
            shift        <= '0;
        end else if (w_advance) begin
            if (w_issue) begin
                out_valid    <= 1'b1;
                opcode_out   <= w_opcode;
                dir_dest_out <= w_dest;
                data_vec1    <= w_vec1;
                data_vec2    <= w_vec2;
                data_sca1    <= w_sca;
                inmediato    <= ELEM_W'(instruccion[7:0]);
                shift        <= ELEM_W'(instruccion[5:3]);
            end else begin
                out_valid    <= 1'b0;
            end
        end
    end

    // Scalar registers 0..LANES-1 broadcast as a vector, lane 0 in the LSBs.
    for (genvar l = 0; l < LANES; l++) begin : g_vfs
        assign VFS[l*ELEM_W +: ELEM_W] = r_sreg[l];
    end

    assign busy_mask = r_busy;

endmodule
`default_nettype wire
